uart_tx_mmio: RTL

Memory-mapped UART transmitter on the `riscv_core` data port, downstream of the core alongside data memory. The block snoops the core's write port for its register window and buffers written bytes in a FIFO. It serializes them 8N1 on `tx`. Reads of its registers use the same 1-cycle synchronous latency as `memory`, and a top-level mux selects `rd_data` using `rd_hit`.

---
 rtl/uart_tx_mmio.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: snoops core writes into a byte FIFO and
// serializes them on tx; exposes TXDATA/STATUS/CTRL with 1-cycle registered reads.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    input  logic [1:0]  wr,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            tx_en;

    logic            wr_txdata;
    logic            wr_ctrl;
    logic            full;
    logic            empty;
    logic            push_ok;
    logic            flush;
    logic            baud_end;
    logic            load;
    logic            busy;
    logic [29:0]     rd_off;
    logic            rd_hit_c;
    logic [31:0]     rd_val_c;
    logic            unused_ok;

    // Write decode ignores addr[1:0] and write size
    assign wr_txdata = (|wr) && (wr_addr[31:2] == BASE_W);
    assign wr_ctrl   = (|wr) && (wr_addr[31:2] == BASE_W + 30'd2);

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = wr_txdata && !full;
    assign flush    = wr_ctrl && wr_data[1];
    assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign busy     = (state != S_IDLE);
    assign load     = !empty && tx_en && ((state == S_IDLE) || ((state == S_STOP) && baud_end));

    assign unused_ok = ^{rd_addr[1:0], wr_addr[1:0], wr_data[31:8]};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data[7:0];
    end

    // FIFO pointers, occupancy and control register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_en    <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (load)    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_ok) - CW'(load);
            end
            if (wr_txdata && full)
                overflow <= 1'b1;
            else if (wr_ctrl && wr_data[2])
                overflow <= 1'b0;
            if (wr_ctrl) tx_en <= wr_data[0];
        end
    end

    // Serializer; STOP chains straight into START when another byte is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (load) begin
                        shreg <= mem[rd_ptr];
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (load) begin
                            shreg <= mem[rd_ptr];
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd_off = rd_addr[31:2] - BASE_W;

    always_comb begin
        rd_hit_c = 1'b0;
        rd_val_c = '0;
        if (rd_off < 30'd3) begin
            rd_hit_c = 1'b1;
            case (rd_off[1:0])
                2'd1:    rd_val_c = {16'b0, 8'(count), 4'b0, overflow, busy, empty, full};
                2'd2:    rd_val_c = {31'b0, tx_en};
                default: rd_val_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_hit  <= rd_hit_c;
            rd_data <= rd_val_c;
        end
    end

endmodule
